sobel_window_fetch: RTL and testbench
=====================================

Name: sobel_window_fetch

Overview:
- Holds the 3x3 pixel window consumed by the Sobel gradient stage.
- Fetches that window from image memory under control of the Sobel controller, which issues load_initial, start_shift and start_move.
- Returns the matching load_done, shift_done and move_done pulses to the controller.
- Tracks window position in raster order and flags the final window.

Parameters:
- IMG_WIDTH, 640, image width in pixels (>=3)
- IMG_HEIGHT, 480, image height in pixels (>=3)
- PIX_W, 8, pixel width in bits
- ADDR_W, 20, memory address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT
- TIMEOUT, 64, read timeout in cycles (used only with RD_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- load_initial  in  1  pulse: reset position to (0,0), fetch full window
- start_shift  in  1  pulse: move window one column right
- start_move  in  1  pulse: move window to next row, col 0
- rd_req  out  1  one-cycle memory read request
- rd_addr  out  ADDR_W  read address, valid with rd_req
- rd_data  in  PIX_W  read data
- rd_valid  in  1  rd_data valid; arrives N>=1 cycles after rd_req
- win_out  out  9*PIX_W  window; pixel[r][c] at bits [(r*3+c)*PIX_W +: PIX_W]
- win_valid  out  1  window holds a complete fetched window
- load_done  out  1  one-cycle pulse
- shift_done  out  1  one-cycle pulse
- move_done  out  1  one-cycle pulse
- all_done  out  1  level: final window (row=IMG_HEIGHT-3, col=IMG_WIDTH-3) valid
- cmd_err  out  1  one-cycle pulse: illegal command rejected
- busy  out  1  fetch in progress

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - All outputs 0.
  - row=0, col=0, state IDLE, staging and window registers 0.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: accepts one command per cycle. Priority is load_initial > start_move > start_shift; lower-priority commands in the same cycle are dropped. Commands arriving while busy=1 are ignored; no error is flagged.
  - REQ: rd_req=1 for exactly one cycle; go to WAIT.
  - WAIT: on rd_valid, write rd_data to staging[idx] and increment idx. If pixels remain, go to REQ; otherwise go to DONE. One outstanding read at a time.
  - DONE: commit staging to window registers atomically and pulse the matching done for one cycle; return to IDLE. win_out never shows a partial window.
- Fetch order:
  - load_initial sets row=col=0, clears win_valid and fetches 9 pixels.
  - start_move sets row=row+1, col=0, clears win_valid and fetches 9 pixels.
  - Full-window fetches run column-major: c=0..2, and for each column r=0..2.
  - rd_addr = (row+r)*IMG_WIDTH + (col+c), truncated to ADDR_W.
- Shift:
  - start_shift fetches 3 pixels of column col+3, r=0..2, then sets col=col+1.
  - Commit shifts window columns 1,2 into 0,1 and loads the new column into 2.
  - win_valid stays 1 throughout.
- Illegal commands, each pulsing cmd_err for one cycle with state, position and window unchanged:
  - start_shift with col=IMG_WIDTH-3 or win_valid=0.
  - start_move with row=IMG_HEIGHT-3.
- busy=1 in REQ, WAIT and DONE.
- Latency: done pulses the cycle after the last rd_valid. Per pixel cost is 1+N cycles.
- Reset mid-fetch: abort immediately and return to reset values. A late rd_valid in IDLE is ignored.
- all_done is recomputed on every commit and is cleared when load_initial or start_move is accepted.

Optional Feature:
- Macro: RD_TIMEOUT_EN.
- Defined: a WAIT counter is added. If TIMEOUT cycles pass without rd_valid:
  - Abort to IDLE and pulse cmd_err.
  - Pulse no done signal.
  - Leave the window and position unchanged.
  - Clear win_valid for an aborted load or move.
- Undefined: no counter; WAIT waits indefinitely.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=4, memory returns addr[7:0], N=2):
- load_initial:
  - rd_addr sequence is 0,4,8,1,5,9,2,6,10.
  - load_done fires once, 27 cycles after acceptance.
  - win_out pixel[r][c]=4r+c; win_valid=1; all_done=0.
- start_shift after load:
  - rd_addr is 3,7,11; shift_done fires.
  - pixel[r][c]=4r+c+1.
  - all_done=0 (row 0).
- Second start_shift at col=1: cmd_err pulses; no rd_req; window unchanged.
- start_move, then start_shift:
  - start_move addresses are 4,8,12,5,9,13,6,10,14; move_done fires.
  - The following start_shift makes pixel[r][c]=4(r+1)+c+1 and all_done=1.
  - A further start_move gives cmd_err.
- Edge cases:
  - load_initial and start_shift in the same cycle: only load is performed.
  - rst asserted during WAIT: all outputs return to 0 immediately; a stray rd_valid afterward has no effect.
- With RD_TIMEOUT_EN and TIMEOUT=8, rd_valid withheld: cmd_err fires 8 cycles into WAIT, no load_done, busy=0.

Source files
------------

// File: rtl/sobel_window_fetch_if.sv
// Controller command, image-memory read and window signals of sobel_window_fetch.
// slave is the fetch block; master is the controller/memory side.
interface sobel_window_fetch_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 20
);
    logic                 load_initial;
    logic                 start_shift;
    logic                 start_move;
    logic                 rd_req;
    logic [ADDR_W-1:0]    rd_addr;
    logic [PIX_W-1:0]     rd_data;
    logic                 rd_valid;
    logic [9*PIX_W-1:0]   win_out;
    logic                 win_valid;
    logic                 load_done;
    logic                 shift_done;
    logic                 move_done;
    logic                 all_done;
    logic                 cmd_err;
    logic                 busy;

    modport slave (
        input  load_initial, start_shift, start_move, rd_data, rd_valid,
        output rd_req, rd_addr, win_out, win_valid, load_done, shift_done,
               move_done, all_done, cmd_err, busy
    );

    modport master (
        output load_initial, start_shift, start_move, rd_data, rd_valid,
        input  rd_req, rd_addr, win_out, win_valid, load_done, shift_done,
               move_done, all_done, cmd_err, busy
    );
endinterface

// File: rtl/sobel_window_fetch.sv
// 3x3 Sobel window fetcher: one outstanding pixel read at a time, atomic window commit.
// Optional macro RD_TIMEOUT_EN adds a TIMEOUT-cycle watchdog on the read wait.
module sobel_window_fetch #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 8,
    parameter int ADDR_W     = 20,
    parameter int TIMEOUT    = 64
) (
    input  logic                clk,
    input  logic                rst,
    sobel_window_fetch_if.slave bus
);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 3);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 3);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {OP_LOAD, OP_MOVE, OP_SHIFT} op_t;
    typedef logic [8:0][PIX_W-1:0] win_t;

    if (IMG_WIDTH < 3 || IMG_HEIGHT < 3 || TIMEOUT < 1 ||
        (longint'(1) << ADDR_W) < longint'(IMG_WIDTH) * longint'(IMG_HEIGHT)) begin : g_param_check
        $error("sobel_window_fetch: illegal parameter set");
    end

    state_t            state_q;
    op_t               op_q;
    logic [RW-1:0]     row_q, frow_q;
    logic [CW-1:0]     col_q, fcol_q, col_d;
    logic [3:0]        idx_q;
    win_t              stage_q, stage_d, win_q;
    logic              last_px;
    logic              win_valid_q, all_done_q, busy_q, cmd_err_q;
    logic              rd_req_q, load_done_q, shift_done_q, move_done_q;
    logic [ADDR_W-1:0] rd_addr_q;
`ifdef RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]     tmo_q;
`endif

    // Full fetches walk idx column-major; shifts fetch rows 0..2 of column col+3.
    function automatic logic [ADDR_W-1:0] addr_f(input logic [RW-1:0] r0, input logic [CW-1:0] c0,
                                                 input logic shift, input logic [3:0] idx);
        logic [31:0] r, c, a;
        if (shift) begin
            r = 32'(idx);
            c = 32'd3;
        end else begin
            r = 32'(idx) % 32'd3;
            c = 32'(idx) / 32'd3;
        end
        a = (32'(r0) + r) * 32'(IMG_WIDTH) + 32'(c0) + c;
        return a[ADDR_W-1:0];
    endfunction

    function automatic win_t commit_f(input win_t win, input win_t stg, input logic shift);
        win_t res;
        for (int r = 0; r < 3; r++) begin
            if (shift) begin
                res[r*3]     = win[r*3+1];
                res[r*3 + 1] = win[r*3+2];
                res[r*3 + 2] = stg[r];
            end else begin
                for (int c = 0; c < 3; c++) res[r*3 + c] = stg[c*3 + r];
            end
        end
        return res;
    endfunction

    always_comb begin
        stage_d        = stage_q;
        stage_d[idx_q] = bus.rd_data;
        col_d          = (op_q == OP_SHIFT) ? fcol_q + CW'(1) : fcol_q;
        last_px        = (op_q == OP_SHIFT) ? (idx_q == 4'd2) : (idx_q == 4'd8);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= OP_LOAD;
            row_q        <= '0;
            col_q        <= '0;
            frow_q       <= '0;
            fcol_q       <= '0;
            idx_q        <= '0;
            stage_q      <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            all_done_q   <= 1'b0;
            busy_q       <= 1'b0;
            cmd_err_q    <= 1'b0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            load_done_q  <= 1'b0;
            shift_done_q <= 1'b0;
            move_done_q  <= 1'b0;
`ifdef RD_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            rd_req_q     <= 1'b0;
            cmd_err_q    <= 1'b0;
            load_done_q  <= 1'b0;
            shift_done_q <= 1'b0;
            move_done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    idx_q <= '0;
                    if (bus.load_initial) begin
                        op_q        <= OP_LOAD;
                        frow_q      <= '0;
                        fcol_q      <= '0;
                        win_valid_q <= 1'b0;
                        all_done_q  <= 1'b0;
                        rd_addr_q   <= addr_f('0, '0, 1'b0, 4'd0);
                        rd_req_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_REQ;
                    end else if (bus.start_move) begin
                        if (row_q == ROW_LAST) begin
                            cmd_err_q <= 1'b1;
                        end else begin
                            op_q        <= OP_MOVE;
                            frow_q      <= row_q + RW'(1);
                            fcol_q      <= '0;
                            win_valid_q <= 1'b0;
                            all_done_q  <= 1'b0;
                            rd_addr_q   <= addr_f(row_q + RW'(1), '0, 1'b0, 4'd0);
                            rd_req_q    <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= S_REQ;
                        end
                    end else if (bus.start_shift) begin
                        if (col_q == COL_LAST || !win_valid_q) begin
                            cmd_err_q <= 1'b1;
                        end else begin
                            op_q      <= OP_SHIFT;
                            frow_q    <= row_q;
                            fcol_q    <= col_q;
                            rd_addr_q <= addr_f(row_q, col_q, 1'b1, 4'd0);
                            rd_req_q  <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    state_q <= S_WAIT;
`ifdef RD_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                end
                // Position and window change only here, so an aborted fetch leaves both intact.
                S_WAIT: begin
                    if (bus.rd_valid) begin
                        stage_q <= stage_d;
                        if (last_px) begin
                            win_q        <= commit_f(win_q, stage_d, op_q == OP_SHIFT);
                            win_valid_q  <= 1'b1;
                            row_q        <= frow_q;
                            col_q        <= col_d;
                            all_done_q   <= (frow_q == ROW_LAST) && (col_d == COL_LAST);
                            load_done_q  <= (op_q == OP_LOAD);
                            move_done_q  <= (op_q == OP_MOVE);
                            shift_done_q <= (op_q == OP_SHIFT);
                            state_q      <= S_DONE;
                        end else begin
                            idx_q     <= idx_q + 4'd1;
                            rd_addr_q <= addr_f(frow_q, fcol_q, op_q == OP_SHIFT, idx_q + 4'd1);
                            rd_req_q  <= 1'b1;
                            state_q   <= S_REQ;
                        end
                    end
`ifdef RD_TIMEOUT_EN
                    else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        cmd_err_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
`endif
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_req     = rd_req_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.win_out    = win_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.load_done  = load_done_q;
    assign bus.shift_done = shift_done_q;
    assign bus.move_done  = move_done_q;
    assign bus.all_done   = all_done_q;
    assign bus.cmd_err    = cmd_err_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sobel_window_fetch.sv
// Bench for sobel_window_fetch on a 4x4 image whose memory returns addr[7:0].
module tb_sobel_window_fetch;
    localparam int W = 4, H = 4, PW = 8, AW = 20, TMO = 8;
    localparam int K_LOAD = 0, K_MOVE = 1, K_SHIFT = 2, K_ERR = 3;

    logic clk = 1'b0;
    logic rst;

    sobel_window_fetch_if #(.PIX_W(PW), .ADDR_W(AW)) bus ();

    sobel_window_fetch #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW), .ADDR_W(AW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, acc_cyc = 0;
    int lat = 2;
    bit mem_en = 1'b1;
    int n_load, n_shift, n_move, n_err, n_req;
    int t_load, t_shift, t_move, t_err;
    int addr_q[$];

    // reference model: window position, flags, and the image window it should hold
    int mrow = 0, mcol = 0;
    bit mwv = 1'b0, mad = 1'b0;
    logic [71:0] mwin = '0;

    typedef struct {
        bit l, m, s;
        int kind;
        int row, col;
        bit ad;
        int p00;
        int a0, alast;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] img_win(input int row, input int col);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3 + c)*8 +: 8] = 8'((row + r)*W + col + c);
        return w;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // memory: rd_valid with addr[7:0] exactly lat cycles after rd_req
    initial begin
        int cd;
        logic [AW-1:0] pend;
        cd = 0;
        pend = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.rd_valid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0 && mem_en) begin
                    bus.rd_valid = 1'b1;
                    bus.rd_data  = pend[7:0];
                end
            end
            if (bus.rd_req === 1'b1) begin
                cd   = lat;
                pend = bus.rd_addr;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus.load_done === 1'b1)  begin n_load++;  t_load  = cyc; end
        if (bus.shift_done === 1'b1) begin n_shift++; t_shift = cyc; end
        if (bus.move_done === 1'b1)  begin n_move++;  t_move  = cyc; end
        if (bus.cmd_err === 1'b1)    begin n_err++;   t_err   = cyc; end
        if (bus.rd_req === 1'b1)     begin n_req++;   addr_q.push_back(int'(bus.rd_addr)); end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_cmd(input bit l, input bit m, input bit s);
        @(posedge clk);
        #1;
        n_load = 0; n_shift = 0; n_move = 0; n_err = 0; n_req = 0;
        addr_q.delete();
        bus.load_initial = l;
        bus.start_move   = m;
        bus.start_shift  = s;
        acc_cyc = cyc + 1;
        @(posedge clk);
        #1;
        bus.load_initial = 1'b0;
        bus.start_move   = 1'b0;
        bus.start_shift  = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input bit l, input bit m, input bit s, input bit interfere);
        int kind, frow, fcol, nrow, ncol, npx, t_done;
        int exp_a[$];
        bit to;
        frow = mrow; fcol = mcol;
        if (l) begin
            kind = K_LOAD; frow = 0; fcol = 0;
        end else if (m) begin
            if (mrow == H-3) kind = K_ERR;
            else begin kind = K_MOVE; frow = mrow + 1; fcol = 0; end
        end else begin
            if (mcol == W-3 || !mwv) kind = K_ERR;
            else kind = K_SHIFT;
        end
        nrow = mrow; ncol = mcol;
        if (kind == K_LOAD || kind == K_MOVE) begin
            for (int c = 0; c < 3; c++)
                for (int r = 0; r < 3; r++) exp_a.push_back((frow + r)*W + fcol + c);
            nrow = frow; ncol = fcol;
        end else if (kind == K_SHIFT) begin
            for (int r = 0; r < 3; r++) exp_a.push_back((frow + r)*W + fcol + 3);
            nrow = frow; ncol = fcol + 1;
        end
        npx = exp_a.size();

        drive_cmd(l, m, s);
        if (interfere && kind != K_ERR) begin
            @(posedge clk);
            #1;
            bus.load_initial = 1'($urandom_range(0, 1));
            bus.start_move   = 1'($urandom_range(0, 1));
            bus.start_shift  = 1'b1;
            @(posedge clk);
            #1;
            bus.load_initial = 1'b0;
            bus.start_move   = 1'b0;
            bus.start_shift  = 1'b0;
        end
        wait_idle(to);

        chk("wait_bound", to, 0);
        chk("rd_req_count", n_req, npx);
        for (int i = 0; i < npx && i < addr_q.size(); i++) chk("rd_addr", addr_q[i], exp_a[i]);
        chk("load_done_count", n_load, kind == K_LOAD);
        chk("move_done_count", n_move, kind == K_MOVE);
        chk("shift_done_count", n_shift, kind == K_SHIFT);
        chk("cmd_err_count", n_err, kind == K_ERR);
        if (kind != K_ERR) begin
            t_done = (kind == K_LOAD) ? t_load : (kind == K_MOVE) ? t_move : t_shift;
            chk("done_latency", t_done - acc_cyc, npx*(1 + lat));
            mrow = nrow; mcol = ncol; mwv = 1'b1;
            mad  = (nrow == H-3) && (ncol == W-3);
            mwin = img_win(nrow, ncol);
        end
        chk("win_out", bus.win_out, mwin);
        chk("win_valid", bus.win_valid, mwv);
        chk("all_done", bus.all_done, mad);
    endtask

    initial begin
        bit to;
        int obs;
        tbl[0] = '{1, 0, 0, K_LOAD,  0, 0, 0, 0, 0, 10};
        tbl[1] = '{0, 0, 1, K_SHIFT, 0, 1, 0, 1, 3, 11};
        tbl[2] = '{0, 0, 1, K_ERR,   0, 1, 0, 1, -1, -1};
        tbl[3] = '{0, 1, 0, K_MOVE,  1, 0, 0, 4, 4, 14};
        tbl[4] = '{0, 0, 1, K_SHIFT, 1, 1, 1, 5, 7, 15};
        tbl[5] = '{0, 1, 0, K_ERR,   1, 1, 1, 5, -1, -1};
        tbl[6] = '{1, 0, 1, K_LOAD,  0, 0, 0, 0, 0, 10};
        tbl[7] = '{0, 1, 1, K_MOVE,  1, 0, 0, 4, 4, 14};
        tbl[8] = '{1, 1, 1, K_LOAD,  0, 0, 0, 0, 0, 10};

        rst = 1'b1;
        bus.load_initial = 1'b0;
        bus.start_move   = 1'b0;
        bus.start_shift  = 1'b0;
        bus.rd_valid     = 1'b0;
        bus.rd_data      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_win_out", bus.win_out, 0);
        chk("reset_ctl", {bus.rd_req, bus.rd_addr, bus.win_valid, bus.load_done, bus.shift_done,
                          bus.move_done, bus.all_done, bus.cmd_err, bus.busy}, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_cmd(tbl[i].l, tbl[i].m, tbl[i].s, 1'b0);
            obs = (n_load == 1) ? K_LOAD : (n_move == 1) ? K_MOVE :
                  (n_shift == 1) ? K_SHIFT : (n_err == 1) ? K_ERR : -1;
            chk("tbl_kind", obs, tbl[i].kind);
            chk("tbl_p00", bus.win_out[7:0], tbl[i].p00);
            chk("tbl_p11", bus.win_out[4*8 +: 8], (tbl[i].row + 1)*W + tbl[i].col + 1);
            chk("tbl_all_done", bus.all_done, tbl[i].ad);
            if (tbl[i].a0 < 0) chk("tbl_no_req", n_req, 0);
            else if (addr_q.size() > 0) begin
                chk("tbl_first_addr", addr_q[0], tbl[i].a0);
                chk("tbl_last_addr", addr_q[addr_q.size()-1], tbl[i].alast);
            end
        end

        for (int i = 0; i < 30; i++) begin
            bit l, m, s;
            l = ($urandom_range(0, 5) == 0);
            m = ($urandom_range(0, 2) == 0);
            s = ($urandom_range(0, 1) == 0);
            if (!l && !m && !s) s = 1'b1;
            lat = $urandom_range(1, 4);
            run_cmd(l, m, s, $urandom_range(0, 3) == 0);
        end

        // reset in the middle of a move fetch, then a stray rd_valid lands in IDLE
        lat = 2;
        run_cmd(1'b1, 1'b0, 1'b0, 1'b0);
        drive_cmd(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset_win_out", bus.win_out, 0);
        chk("midreset_ctl", {bus.rd_req, bus.rd_addr, bus.win_valid, bus.load_done, bus.shift_done,
                             bus.move_done, bus.all_done, bus.cmd_err, bus.busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("stray_busy", bus.busy, 0);
        chk("stray_win_valid", bus.win_valid, 0);
        chk("stray_win_out", bus.win_out, 0);
        chk("stray_done", n_load + n_move + n_shift, 0);
        mrow = 0; mcol = 0; mwv = 1'b0; mad = 1'b0; mwin = '0;
        run_cmd(1'b0, 1'b0, 1'b1, 1'b0);
        run_cmd(1'b1, 1'b0, 1'b0, 1'b0);

`ifdef RD_TIMEOUT_EN
        mem_en = 1'b0;
        drive_cmd(1'b1, 1'b0, 1'b0);
        wait_idle(to);
        chk("tmo_bound", to, 0);
        chk("tmo_cmd_err", n_err, 1);
        chk("tmo_err_cycle", t_err - acc_cyc, TMO + 1);
        chk("tmo_no_done", n_load, 0);
        chk("tmo_busy", bus.busy, 0);
        chk("tmo_win_valid", bus.win_valid, 0);
        chk("tmo_win_out", bus.win_out, mwin);
        mem_en = 1'b1;
        mwv = 1'b0; mad = 1'b0;
        repeat (6) @(posedge clk);
        run_cmd(1'b1, 1'b0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
